// File: rtl/hub75_row_receiver.sv
// HUB75 panel-side row receiver: synchronizes the panel bus, deserializes the six
// colour lanes per row and hands each latched row to a ready/valid consumer.

module hub75_sync #(
  parameter int W      = 13,
  parameter int STAGES = 2
) (
  input  logic         CLK_I,
  input  logic         RSTN_I,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // One shared chain for every input so data and shift clock stay aligned.
  logic [STAGES-1:0][W-1:0] pipe;

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) pipe <= '0;
    else         pipe <= {pipe[STAGES-2:0], d};
  end

  assign q = pipe[STAGES-1];
endmodule

module hub75_lane #(
  parameter int WIDTH = 32
) (
  input  logic             CLK_I,
  input  logic             RSTN_I,
  input  logic             clr,
  input  logic             wr,
  input  logic [6:0]       idx,
  input  logic             din,
  output logic [WIDTH-1:0] word
);
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) word <= '0;
    else if (clr) word <= '0;
    else begin
      for (int b = 0; b < WIDTH; b++)
        if (wr && idx == 7'(b)) word[b] <= din;
    end
  end
endmodule

module hub75_row_receiver #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLK_I,
  input  logic                 RSTN_I,
  input  logic                 R0,
  input  logic                 G0,
  input  logic                 B0,
  input  logic                 R1,
  input  logic                 G1,
  input  logic                 B1,
  input  logic                 RA,
  input  logic                 RB,
  input  logic                 RC,
  input  logic                 RD,
  input  logic                 CLK_IN,
  input  logic                 LATCH,
  input  logic                 OE,
  output logic [6*WIDTH-1:0]   ROW_DATA,
  output logic [3:0]           ROW_ADDR,
  output logic [6:0]           ROW_BITS,
  output logic [15:0]          ROW_ON_TIME,
  output logic                 ROW_VALID,
  input  logic                 ROW_READY,
  output logic                 OVERRUN
);
  localparam int         NUM_LANES = 6;
  localparam int         NIN       = 13;
  localparam logic [6:0] WIDTH_C   = 7'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

  logic [NIN-1:0]                      raw, syn;
  logic [NUM_LANES-1:0]                col_s;
  logic [3:0]                          addr_s;
  logic                                clk_s, latch_s, oe_s;
  logic                                clk_q, latch_q;
  logic                                shift_evt, latch_evt, wr, load;
  logic [6:0]                          bit_cnt;
  logic [15:0]                         oe_cnt;
  state_t                              state, state_nxt;
  logic [NUM_LANES-1:0][WIDTH-1:0]     words, row_data_q;

  assign raw = {OE, LATCH, CLK_IN, RD, RC, RB, RA, R0, G0, B0, R1, G1, B1};

  hub75_sync #(.W(NIN), .STAGES(SYNC_STAGES)) u_sync (
    .CLK_I (CLK_I),
    .RSTN_I(RSTN_I),
    .d     (raw),
    .q     (syn)
  );

  assign col_s   = syn[5:0];
  assign addr_s  = syn[9:6];
  assign clk_s   = syn[10];
  assign latch_s = syn[11];
  assign oe_s    = syn[12];

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      clk_q   <= 1'b0;
      latch_q <= 1'b0;
    end else begin
      clk_q   <= clk_s;
      latch_q <= latch_s;
    end
  end

  // Latch wins over a coincident shift edge.
  assign latch_evt = latch_s & ~latch_q;
  assign shift_evt = clk_s & ~clk_q & ~latch_evt;
  assign wr        = shift_evt && (state != FULL) && (bit_cnt < WIDTH_C);
  assign load      = latch_evt && (!ROW_VALID || ROW_READY);

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (shift_evt) state_nxt = SHIFT;
      SHIFT:   if (bit_cnt >= WIDTH_C) state_nxt = FULL;
      FULL:    state_nxt = FULL;
      default: state_nxt = IDLE;
    endcase
    if (latch_evt) state_nxt = IDLE;
  end

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I)                           bit_cnt <= '0;
    else if (latch_evt)                    bit_cnt <= '0;
    else if (shift_evt && bit_cnt != 7'h7F) bit_cnt <= bit_cnt + 7'd1;
  end

  // Counts OE-low cycles of the row period now ending; sampled, then restarted.
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I)                         oe_cnt <= '0;
    else if (latch_evt)                  oe_cnt <= '0;
    else if (!oe_s && oe_cnt != 16'hFFFF) oe_cnt <= oe_cnt + 16'd1;
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    hub75_lane #(.WIDTH(WIDTH)) u_lane (
      .CLK_I (CLK_I),
      .RSTN_I(RSTN_I),
      .clr   (latch_evt),
      .wr    (wr),
      .idx   (bit_cnt),
      .din   (col_s[l]),
      .word  (words[l])
    );
  end

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      row_data_q  <= '0;
      ROW_ADDR    <= '0;
      ROW_BITS    <= '0;
      ROW_ON_TIME <= '0;
      ROW_VALID   <= 1'b0;
      OVERRUN     <= 1'b0;
    end else begin
      if (load) begin
        row_data_q  <= words;
        ROW_ADDR    <= addr_s;
        ROW_BITS    <= bit_cnt;
        ROW_ON_TIME <= oe_cnt;
        ROW_VALID   <= 1'b1;
      end else if (ROW_VALID && ROW_READY) begin
        ROW_VALID   <= 1'b0;
      end
      if (latch_evt && ROW_VALID && !ROW_READY) OVERRUN <= 1'b1;
    end
  end

  assign ROW_DATA = row_data_q;
endmodule

// File: tb/tb_hub75_row_receiver.sv
// Directed bench for hub75_row_receiver with hand-computed expected rows.

module tb_hub75_row_receiver;
  logic         clk, rst_n;
  logic         r0, g0, b0, r1, g1, b1;
  logic         ra, rb, rc, rd;
  logic         clk_in, latch, oe, ready;
  logic [191:0] row_data;
  logic [3:0]   row_addr;
  logic [6:0]   row_bits;
  logic [15:0]  row_on_time;
  logic         row_valid, overrun;

  int n_cmp = 0;
  int n_bad = 0;

  hub75_row_receiver #(.WIDTH(32), .SYNC_STAGES(2)) dut (
    .CLK_I      (clk),
    .RSTN_I     (rst_n),
    .R0         (r0),
    .G0         (g0),
    .B0         (b0),
    .R1         (r1),
    .G1         (g1),
    .B1         (b1),
    .RA         (ra),
    .RB         (rb),
    .RC         (rc),
    .RD         (rd),
    .CLK_IN     (clk_in),
    .LATCH      (latch),
    .OE         (oe),
    .ROW_DATA   (row_data),
    .ROW_ADDR   (row_addr),
    .ROW_BITS   (row_bits),
    .ROW_ON_TIME(row_on_time),
    .ROW_VALID  (row_valid),
    .ROW_READY  (ready),
    .OVERRUN    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic shift_bit(input logic [5:0] c);
    @(negedge clk);
    {r0, g0, b0, r1, g1, b1} = c;
    clk_in = 1'b0;
    repeat (2) @(negedge clk);
    clk_in = 1'b1;
    repeat (2) @(negedge clk);
    clk_in = 1'b0;
  endtask

  // words packed R0 at MSBs; bits beyond 32 shift all-ones
  task automatic send_bits(input logic [191:0] words, input int nbits, input logic [3:0] a);
    logic [5:0][31:0] w;
    w = words;
    {rd, rc, rb, ra} = a;
    for (int i = 0; i < nbits; i++) begin
      if (i < 32) shift_bit({w[5][i], w[4][i], w[3][i], w[2][i], w[1][i], w[0][i]});
      else        shift_bit(6'h3F);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic latch_row();
    @(negedge clk);
    latch = 1'b1;
    repeat (2) @(negedge clk);
    latch = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic consume();
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  logic [191:0] row33, ones, pat40, pat_c, pat_d;

  initial begin
    row33 = {32'h55F00574, 32'hAA0F056A, 32'h5500F559, 32'h0057455F, 32'hF056AAA0, 32'h0F559550};
    ones  = {6{32'hFFFFFFFF}};
    pat40 = {6{32'h12345678}};
    pat_c = {6{32'hA5A5A5A5}};
    pat_d = {6{32'h0F0F0F0F}};
    {r0, g0, b0, r1, g1, b1} = '0;
    {rd, rc, rb, ra} = '0;
    clk_in = 1'b0; latch = 1'b0; oe = 1'b1; ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 192'(row_valid), 192'd0);
    chk("rst_overrun", 192'(overrun), 192'd0);
    chk("rst_data", row_data, 192'd0);
    chk("rst_addr", 192'(row_addr), 192'd0);
    chk("rst_bits", 192'(row_bits), 192'd0);
    chk("rst_on_time", 192'(row_on_time), 192'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // basic row with latency check
    send_bits(row33, 32, 4'h3);
    @(negedge clk);
    latch = 1'b1;
    repeat (2) @(negedge clk);
    chk("lat_detect_cycle", 192'(row_valid), 192'd0);
    @(negedge clk);
    chk("lat_valid_rise", 192'(row_valid), 192'd1);
    latch = 1'b0;
    repeat (2) @(negedge clk);
    chk("row33_data", row_data, row33);
    chk("row33_addr", 192'(row_addr), 192'd3);
    chk("row33_bits", 192'(row_bits), 192'd32);
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("row33_drop_valid", 192'(row_valid), 192'd0);

    // on-time of 100 cycles
    @(negedge clk);
    oe = 1'b0;
    repeat (100) @(negedge clk);
    oe = 1'b1;
    repeat (4) @(negedge clk);
    latch_row();
    chk("on100", 192'(row_on_time), 192'd100);
    chk("on100_bits", 192'(row_bits), 192'd0);
    consume();

    // short and long rows
    send_bits(ones, 31, 4'h7);
    latch_row();
    chk("b31_bits", 192'(row_bits), 192'd31);
    chk("b31_data", row_data, {6{32'h7FFFFFFF}});
    chk("b31_addr", 192'(row_addr), 192'd7);
    consume();
    send_bits(pat40, 40, 4'hA);
    latch_row();
    chk("b40_bits", 192'(row_bits), 192'd40);
    chk("b40_data", row_data, pat40);
    consume();

    // latch coincident with a transfer
    send_bits(pat_c, 32, 4'h1);
    latch_row();
    chk("xfer_c_data", row_data, pat_c);
    send_bits(pat_d, 32, 4'h2);
    @(negedge clk);
    latch = 1'b1;
    repeat (2) @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("xfer_valid", 192'(row_valid), 192'd1);
    chk("xfer_data", row_data, pat_d);
    chk("xfer_addr", 192'(row_addr), 192'd2);
    chk("xfer_overrun", 192'(overrun), 192'd0);
    latch = 1'b0;
    repeat (3) @(negedge clk);
    consume();
    chk("xfer_consumed", 192'(row_valid), 192'd0);

    // overrun
    send_bits(ones, 32, 4'h5);
    latch_row();
    send_bits(row33, 31, 4'h9);
    latch_row();
    chk("ovr_valid", 192'(row_valid), 192'd1);
    chk("ovr_data", row_data, ones);
    chk("ovr_addr", 192'(row_addr), 192'd5);
    chk("ovr_bits", 192'(row_bits), 192'd32);
    chk("ovr_flag", 192'(overrun), 192'd1);
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("ovr_release", 192'(row_valid), 192'd0);
    repeat (3) @(negedge clk);
    chk("ovr_sticky", 192'(overrun), 192'd1);

    // on-time saturation
    @(negedge clk);
    oe = 1'b0;
    repeat (70000) @(negedge clk);
    oe = 1'b1;
    repeat (4) @(negedge clk);
    latch_row();
    chk("on_sat", 192'(row_on_time), 192'hFFFF);

    // reset mid-row
    send_bits(ones, 10, 4'h4);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_valid", 192'(row_valid), 192'd0);
    chk("mid_rst_overrun", 192'(overrun), 192'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_bits(ones, 32, 4'h4);
    latch_row();
    chk("post_rst_data", row_data, ones);
    chk("post_rst_bits", 192'(row_bits), 192'd32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hub75_row_receiver.md
HUB75_ROW_RECEIVER -- requirements
Module: hub75_row_receiver

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the number of columns per row shift register.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth on every panel-side input (minimum 2).
REQ-003 SHALL use one clock and an asynchronous, active-low reset; all state in the CLK_I domain.
REQ-004 CLK_I  in  1  system clock; SHALL be at least 4x the panel shift clock.
REQ-005 RSTN_I  in  1  asynchronous active-low reset.
REQ-006 R0,G0,B0,R1,G1,B1  in  1 each  serial colour data, top/bottom bank.
REQ-007 RA,RB,RC,RD  in  1 each  row address, RA = LSB.
REQ-008 CLK_IN  in  1  panel shift clock.
REQ-009 LATCH  in  1  active-high latch.
REQ-010 OE  in  1  active-low output enable.
REQ-011 ROW_DATA  out  6*WIDTH  {R0,G0,B0,R1,G1,B1} words, R0 word at MSBs.
REQ-012 ROW_ADDR  out  4  {RD,RC,RB,RA} captured with the row.
REQ-013 ROW_BITS  out  7  CLK_IN rising edges counted for the row.
REQ-014 ROW_ON_TIME  out  16  CLK_I cycles with OE low during the previous row period.
REQ-015 ROW_VALID  out  1  row available; ROW_READY  in  1  consumer accepts.
REQ-016 OVERRUN  out  1  sticky: a latched row was dropped.

Function
REQ-017 All panel inputs SHALL pass through identical SYNC_STAGES flip-flop chains, preserving data/clock alignment.
REQ-018 A shift event SHALL be a synchronized CLK_IN 0->1 transition; a latch event SHALL be a synchronized LATCH 0->1 transition.
REQ-019 On a shift event with bit counter n < WIDTH, each colour input SHALL be stored at bit n of its word (first bit -> bit 0); when n >= WIDTH, data SHALL be discarded.
REQ-020 The bit counter SHALL increment per shift event and saturate at 127.
REQ-021 Shift FSM: IDLE (n=0) -> SHIFT on a shift event; SHIFT -> FULL when n reaches WIDTH; any state -> IDLE on a latch event.
REQ-022 On a latch event with ROW_VALID low, or with ROW_VALID and ROW_READY both high, the block SHALL load ROW_DATA, ROW_ADDR (synchronized address at that cycle), ROW_BITS = n and ROW_ON_TIME.
REQ-023 ROW_VALID SHALL rise exactly one CLK_I cycle after the latch-event detection cycle.
REQ-024 On a latch event with ROW_VALID high and ROW_READY low, the new row SHALL be dropped, outputs SHALL be held, and OVERRUN SHALL be set.
REQ-025 OVERRUN SHALL clear only on reset.
REQ-026 A transfer occurs when ROW_VALID and ROW_READY are both high; ROW_VALID SHALL then fall next cycle unless a latch event loads a new row in the same cycle, in which case it stays high.
REQ-027 ROW_DATA/ROW_ADDR/ROW_BITS/ROW_ON_TIME SHALL be stable while ROW_VALID is high.
REQ-028 A latch event SHALL clear the bit counter and the shift words to 0, whether or not the row was loaded.
REQ-029 The OE counter SHALL count CLK_I cycles with synchronized OE low, saturate at 0xFFFF, and restart from 0 on each latch event after its value is sampled.
REQ-030 A shift event and a latch event in the same cycle: the latch SHALL take priority and the shift SHALL be ignored.

Reset
REQ-031 RSTN_I low SHALL immediately clear synchronizers, counters, shift words, the FSM (IDLE), ROW_DATA, ROW_ADDR, ROW_BITS, ROW_ON_TIME, ROW_VALID and OVERRUN to 0.
REQ-032 Reset mid-row SHALL discard the partial row; the first shift event after release SHALL write bit 0.

Verification
REQ-033 Shift 32 bits R0=0x55F00574 LSB-first, G0=0xAA0F056A, B0=0x5500F559, R1=0x0057455F, G1=0xF056AAA0, B1=0x0F559550, address 4'h3, latch -> ROW_DATA matches, ROW_ADDR=3, ROW_BITS=32, ROW_VALID high with latency per REQ-023.
REQ-034 Hold ROW_READY low, send two rows -> first row held, OVERRUN=1; assert ROW_READY -> ROW_VALID falls next cycle.
REQ-035 Send 31 bits then latch -> ROW_BITS=31, bit 31 of every word = 0; send 40 bits -> ROW_BITS=40, only the first 32 bits stored.
REQ-036 OE low for 100 CLK_I cycles before latch -> ROW_ON_TIME=100; OE low 70000 cycles -> 0xFFFF.
REQ-037 Latch coincident with a ROW_VALID/ROW_READY transfer -> ROW_VALID stays 1, new data loaded, OVERRUN stays 0.
REQ-038 Reset after 10 shift events, then 32 bits of all-ones and latch -> every word = 0xFFFFFFFF, ROW_BITS=32.
